// File: rtl/wgt_load_ctrl.sv
// Weight-load controller: streams one filter set from weight memory into the banks, then recirculates them per compute pass.
// Optional macro WGT_CTRL_PAUSE_EN adds a pause input that stalls LOAD and COMPUTE.
module wgt_load_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int BUFFER_SIZE  = 27,
    parameter int BUFFER_COUNT = 16,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef WGT_CTRL_PAUSE_EN
    input  logic                    pause,
`endif
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [15:0]             num_windows,
    input  logic [BUFFER_COUNT-1:0] active_filters,
    output logic                    wgt_rd_en,
    output logic [ADDR_WIDTH-1:0]   wgt_rd_addr,
    output logic                    select_wgt,
    output logic [BUFFER_COUNT-1:0] wgt_RF_shift_en,
    output logic                    window_done,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_DRAIN   = 3'd2,
        S_COMPUTE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int TAP_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(BUFFER_SIZE - 1);

    // Weight width only matters to the register file; nothing here depends on it.
    if (DATA_WIDTH < 1) begin : g_bad_data_width
    end

    state_t                  state_q, state_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic [15:0]             win_q, win_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [15:0]             num_q, num_d;
    logic [BUFFER_COUNT-1:0] mask_q, mask_d;

    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    select_q, select_d;
    logic [BUFFER_COUNT-1:0] shift_q, shift_d;
    logic                    wdone_q, wdone_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    pause_s;
    logic                    hold_s;

`ifdef WGT_CTRL_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    // Next-state, counters and the registered output values for the coming cycle.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        win_d   = win_q;
        base_d  = base_q;
        num_d   = num_q;
        mask_d  = mask_q;
        hold_s  = pause_s && ((state_q == S_LOAD) || (state_q == S_COMPUTE));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    num_d   = num_windows;
                    mask_d  = active_filters;
                    tap_d   = '0;
                    win_d   = 16'd0;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (hold_s) begin
                    state_d = S_LOAD;
                end else if (tap_q == TAP_LAST) begin
                    tap_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    tap_d   = tap_q + TAP_W'(1);
                end
            end
            S_DRAIN: begin
                tap_d = '0;
                win_d = 16'd0;
                if (num_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (hold_s) begin
                    state_d = S_COMPUTE;
                end else if (tap_q == TAP_LAST) begin
                    tap_d = '0;
                    if (win_q == (num_q - 16'd1)) begin
                        state_d = S_DONE;
                    end else begin
                        win_d = win_q + 16'd1;
                    end
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d  = (state_d == S_LOAD) && !hold_s;
        addr_d   = rd_en_d ? (base_d + ADDR_WIDTH'(tap_d)) : '0;
        select_d = (state_d == S_LOAD) || (state_d == S_DRAIN);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        // Load data returns one cycle after the strobe, so the shift follows the previous rd_en.
        if (select_d) begin
            shift_d = {BUFFER_COUNT{rd_en_q}} & mask_d;
        end else if ((state_d == S_COMPUTE) && !hold_s) begin
            shift_d = mask_d;
        end else begin
            shift_d = '0;
        end
        wdone_d = (state_d == S_COMPUTE) && !hold_s && (tap_d == TAP_LAST);
    end

    // State, counters, latched job parameters and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            win_q    <= 16'd0;
            base_q   <= '0;
            num_q    <= 16'd0;
            mask_q   <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            select_q <= 1'b0;
            shift_q  <= '0;
            wdone_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            win_q    <= win_d;
            base_q   <= base_d;
            num_q    <= num_d;
            mask_q   <= mask_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            select_q <= select_d;
            shift_q  <= shift_d;
            wdone_q  <= wdone_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign wgt_rd_en       = rd_en_q;
    assign wgt_rd_addr     = addr_q;
    assign select_wgt      = select_q;
    assign wgt_RF_shift_en = shift_q;
    assign window_done     = wdone_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// Scoreboard bench for wgt_load_ctrl: a job-level model pushes the expected per-cycle outputs, a negedge monitor compares.
module tb_wgt_load_ctrl;

    localparam int BS = 27;

    typedef struct packed {
        logic        rd_en;
        logic [9:0]  addr;
        logic        sel;
        logic [15:0] shift;
        logic        wd;
        logic        busy;
        logic        done;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [15:0] num_windows;
    logic [15:0] active_filters;
    logic        wgt_rd_en;
    logic [9:0]  wgt_rd_addr;
    logic        select_wgt;
    logic [15:0] wgt_RF_shift_en;
    logic        window_done;
    logic        busy;
    logic        done;
`ifdef WGT_CTRL_PAUSE_EN
    logic        pause;
`endif

    out_t sb_q[$];
    int   n_checks;
    int   n_fail;
    int   shift_cnt;

    wgt_load_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef WGT_CTRL_PAUSE_EN
        .pause          (pause),
`endif
        .start          (start),
        .base_addr      (base_addr),
        .num_windows    (num_windows),
        .active_filters (active_filters),
        .wgt_rd_en      (wgt_rd_en),
        .wgt_rd_addr    (wgt_rd_addr),
        .select_wgt     (select_wgt),
        .wgt_RF_shift_en(wgt_RF_shift_en),
        .window_done    (window_done),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per cycle while a job is queued, otherwise the idle all-zero state.
    always @(negedge clk) begin
        out_t act;
        out_t exp;
        act = {wgt_rd_en, wgt_rd_addr, select_wgt, wgt_RF_shift_en, window_done, busy, done};
        exp = '0;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL outputs t=%0t actual rd=%b addr=%h sel=%b sh=%h wd=%b busy=%b done=%b required rd=%b addr=%h sel=%b sh=%h wd=%b busy=%b done=%b",
                     $time, act.rd_en, act.addr, act.sel, act.shift, act.wd, act.busy, act.done,
                     exp.rd_en, exp.addr, exp.sel, exp.shift, exp.wd, exp.busy, exp.done);
        end
        if (wgt_RF_shift_en != 16'h0000) shift_cnt++;
    end

    // Expected outputs of one job, cycle 0 being the cycle start is presented.
    task automatic push_trace(input logic [9:0] base, input logic [15:0] nw, input logic [15:0] mask,
                              input int p_at, input int p_len, output int len);
        out_t e;
        int   n;
        n = 0;
        e = '0;
        sb_q.push_back(e); n++;
        for (int k = 0; k < BS; k++) begin
            e = '0;
            e.rd_en = 1'b1;
            e.addr  = base + 10'(k);
            e.sel   = 1'b1;
            e.busy  = 1'b1;
            e.shift = (k == 0) ? 16'h0000 : mask;
            sb_q.push_back(e); n++;
        end
        e = '0;
        e.sel = 1'b1; e.busy = 1'b1; e.shift = mask;
        sb_q.push_back(e); n++;
        for (int j = 0; j < int'(nw) * BS; j++) begin
            e = '0;
            e.busy  = 1'b1;
            e.shift = mask;
            e.wd    = ((j % BS) == BS - 1);
            sb_q.push_back(e); n++;
            if (n - 1 == p_at) begin
                for (int b = 0; b < p_len; b++) begin
                    e = '0;
                    e.busy = 1'b1;
                    sb_q.push_back(e); n++;
                end
            end
        end
        e = '0;
        e.busy = 1'b1; e.done = 1'b1;
        sb_q.push_back(e); n++;
        len = n;
    endtask

    task automatic run_job(input logic [9:0] base, input logic [15:0] nw, input logic [15:0] mask,
                           input int p_at, input int p_len, input int abort_at);
        int len;
        int exp_shifts;
        bit aborted;
        aborted = 1'b0;
        @(posedge clk); #1;
        base_addr      = base;
        num_windows    = nw;
        active_filters = mask;
        start          = 1'b1;
        shift_cnt      = 0;
        push_trace(base, nw, mask, p_at, p_len, len);
        for (int i = 1; i < len; i++) begin
            @(posedge clk); #1;
            start          = 1'($urandom_range(0, 1));
            base_addr      = 10'($urandom);
            num_windows    = 16'($urandom_range(0, 5));
            active_filters = 16'($urandom);
`ifdef WGT_CTRL_PAUSE_EN
            pause = (i >= p_at) && (i < p_at + p_len);
`endif
            if (i == abort_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                sb_q.delete();
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
`ifdef WGT_CTRL_PAUSE_EN
        pause = 1'b0;
`endif
        if (!aborted) begin
            exp_shifts = (mask != 16'h0000) ? (BS + int'(nw) * BS) : 0;
            n_checks++;
            if (shift_cnt != exp_shifts) begin
                n_fail++;
                $display("FAIL shift_count actual=%0d required=%0d", shift_cnt, exp_shifts);
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        shift_cnt      = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        base_addr      = 10'h000;
        num_windows    = 16'd0;
        active_filters = 16'h0000;
`ifdef WGT_CTRL_PAUSE_EN
        pause          = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_job(10'h100, 16'd2, 16'hFFFF, -1, 0, -1);
        run_job(10'h055, 16'd0, 16'h1234, -1, 0, -1);
        run_job(10'h2A0, 16'd3, 16'h00A5, -1, 0, -1);
        run_job(10'h3F0, 16'd1, 16'h0F0F, -1, 0, -1);
        run_job(10'h100, 16'd2, 16'hFFFF, -1, 0, 40);
        repeat (3) @(posedge clk);
        run_job(10'h123, 16'd1, 16'hFFFF, -1, 0, -1);
        run_job(10'h200, 16'd1, 16'h0000, -1, 0, -1);
`ifdef WGT_CTRL_PAUSE_EN
        run_job(10'h010, 16'd2, 16'hFFFF, 45, 5, -1);
`endif
        for (int r = 0; r < 8; r++) begin
            run_job(10'($urandom), 16'($urandom_range(0, 3)), 16'($urandom), -1, 0, -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wgt_load_ctrl.md
WGT_LOAD_CTRL -- requirements
Module: wgt_load_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 8: weight width; carried for consistency with the weight register file, no datapath here.
- BUFFER_SIZE, 27: weights per filter (3x3x3).
- BUFFER_COUNT, 16: filters/banks.
- ADDR_WIDTH, 10: weight memory address width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin one load+compute job.
- base_addr, in, ADDR_WIDTH: first weight memory word.
- num_windows, in, 16: number of 27-cycle compute passes.
- active_filters, in, BUFFER_COUNT: per-bank enable mask.
- wgt_rd_en, out, 1: weight memory read strobe.
- wgt_rd_addr, out, ADDR_WIDTH: read address.
- select_wgt, out, 1: 1 = banks take new data; 0 = banks recirculate.
- wgt_RF_shift_en, out, BUFFER_COUNT: per-bank shift enable.
- window_done, out, 1: last cycle of a compute pass.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle job-complete pulse.
REQ-003 The clock SHALL be clk; reset SHALL be rst_n, asynchronous, active-low.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, DRAIN, COMPUTE, DONE; all outputs SHALL be registered.
REQ-005 IDLE: start=1 SHALL latch base_addr, num_windows and active_filters and enter LOAD next cycle; start SHALL be ignored outside IDLE.
REQ-006 LOAD SHALL last exactly BUFFER_SIZE cycles, with wgt_rd_en=1 and wgt_rd_addr=base_addr+k for k=0..BUFFER_SIZE-1; the address SHALL wrap modulo 2^ADDR_WIDTH.
REQ-007 The memory read latency is 1 cycle, so wgt_RF_shift_en(t+1) SHALL equal {BUFFER_COUNT{wgt_rd_en(t)}} & latched mask during LOAD and DRAIN.
REQ-008 select_wgt SHALL be 1 during LOAD and DRAIN, and 0 otherwise.
REQ-009 DRAIN SHALL last 1 cycle, covering the final shift; it SHALL then go to COMPUTE, or to DONE if num_windows==0.
REQ-010 COMPUTE SHALL assert wgt_RF_shift_en=mask every cycle for num_windows*BUFFER_SIZE cycles, using a tap counter 0..BUFFER_SIZE-1 and a window counter.
- window_done SHALL be 1 when the tap counter is BUFFER_SIZE-1.
- After the last window, the FSM SHALL go to DONE.
REQ-011 DONE SHALL last 1 cycle with done=1, wgt_RF_shift_en=0 and wgt_rd_en=0, then return to IDLE; start in DONE SHALL be ignored.
REQ-012 Banks with a 0 in active_filters SHALL never see shift_en; an all-zero mask SHALL still run the full FSM timing.
REQ-013 Because the banks recirculate exactly BUFFER_SIZE times per pass, every pass SHALL end with the weights at their original alignment.

Reset
REQ-014 While rst_n=0:
- state SHALL be IDLE and all counters 0.
- wgt_rd_en, select_wgt, wgt_RF_shift_en, window_done, busy and done SHALL be 0; wgt_rd_addr SHALL be 0.
REQ-015 Reset asserted mid-job SHALL abort the job immediately with no done pulse; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-016 Macro WGT_CTRL_PAUSE_EN SHALL control an optional pause feature.
- Defined: add input pause (1 bit). In LOAD and COMPUTE, pause=1 SHALL hold state and counters and force wgt_rd_en=0; in COMPUTE it SHALL also force wgt_RF_shift_en=0 and window_done=0. The LOAD/DRAIN shift pipeline of REQ-007 SHALL still follow wgt_rd_en, so no returning data is lost. pause SHALL have no effect in IDLE, DRAIN or DONE.
- Undefined: there SHALL be no pause port, and behaviour SHALL be as if pause=0.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- start at cycle 0, base_addr=0x100, num_windows=2, mask=0xFFFF -> rd_en cycles 1-27 with addr 0x100-0x11A; shift_en=0xFFFF cycles 2-28 with select_wgt=1; cycles 29-82 shift_en=0xFFFF with select_wgt=0; window_done at cycles 55 and 82; done at cycle 83.
- num_windows=0 -> done one cycle after DRAIN, with no select_wgt=0 shift cycles.
- mask=0x00A5 -> shift_en never shows bits outside 0x00A5.
- base_addr=0x3F0 -> addresses wrap 0x3FF to 0x000 after 16 reads.
- rst_n low at cycle 40 of a job -> all outputs 0 at once, no done; a new start later runs a normal job.
- With WGT_CTRL_PAUSE_EN, pause for 5 cycles mid-COMPUTE -> done arrives 5 cycles later and the total shift_en-high cycle count is unchanged.
